// File: rtl/mac_operand_feeder.sv
// Operand FIFO and sequencer for the 8x8 MAC: issues one pair per cycle, drains, captures the dot product, clears.
// Build macro MAC_FEED_LEN_GUARD_EN: force-terminate vectors at MAX_LEN pairs and flag dot_ovf.
module mac_operand_feeder #(
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 1,
    parameter int MAX_LEN = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_a_i,
    input  logic [7:0]  in_b_i,
    input  logic        in_last_i,
    output logic [7:0]  mac_a_o,
    output logic [7:0]  mac_b_o,
    output logic        mac_clr_o,
    input  logic [21:0] mac_result_i,
    output logic        dot_valid_o,
    output logic [21:0] dot_result_o,
    output logic [6:0]  dot_len_o,
    output logic        dot_ovf_o
);
    // state | meaning
    // RUN   | pop one pair per cycle while the FIFO holds data, bubbles otherwise
    // DRAIN | MAC_LAT+1 idle cycles so the last product lands, capture on the final edge
    // CLEAR | mac_clr high for one cycle; may already pop the next vector's first pair

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(MAC_LAT + 2);
    localparam logic [AW:0]   PTR_ONE    = 1;
    localparam logic [DW-1:0] DRAIN_ONE  = 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(MAC_LAT);
    localparam logic [6:0]    MAX_LEN_C  = 7'(MAX_LEN);
`ifdef MAC_FEED_LEN_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [16:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [6:0]    cnt_q, cnt_d, cnt_base, cnt_inc;
    logic [DW-1:0] drain_q, drain_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [7:0]    mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic          mac_clr_q, mac_clr_d;
    logic          dot_valid_q, dot_valid_d, dot_ovf_q, dot_ovf_d;
    logic [21:0]   dot_result_q, dot_result_d;
    logic [6:0]    dot_len_q, dot_len_d;
    logic          full, empty, push, pop, len_hit;
    logic [16:0]   head;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready_o = rst_i && !full;
    assign push       = in_valid_i && in_ready_o;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_base   = (state_q == S_CLEAR) ? 7'd0 : cnt_q;
    assign cnt_inc    = cnt_base + 7'd1;
    assign len_hit    = GUARD_EN && (cnt_inc == MAX_LEN_C);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        ovf_pend_d   = ovf_pend_q;
        pop          = 1'b0;
        mac_a_d      = 8'd0;
        mac_b_d      = 8'd0;
        mac_clr_d    = 1'b0;
        dot_valid_d  = 1'b0;
        dot_result_d = dot_result_q;
        dot_len_d    = dot_len_q;
        dot_ovf_d    = dot_ovf_q;
        case (state_q)
            S_RUN, S_CLEAR: begin
                // The MAC clears on the edge that leaves CLEAR, so a pair popped there starts from zero.
                state_d = S_RUN;
                cnt_d   = cnt_base;
                if (!empty) begin
                    pop     = 1'b1;
                    mac_a_d = head[15:8];
                    mac_b_d = head[7:0];
                    cnt_d   = (&cnt_base) ? cnt_base : cnt_inc;
                    if (head[16] || len_hit) begin
                        state_d    = S_DRAIN;
                        drain_d    = DRAIN_LOAD;
                        ovf_pend_d = len_hit && !head[16];
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d      = S_CLEAR;
                    mac_clr_d    = 1'b1;
                    dot_valid_d  = 1'b1;
                    dot_result_d = mac_result_i;
                    dot_len_d    = cnt_q;
                    dot_ovf_d    = ovf_pend_q;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_CLEAR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            ovf_pend_q   <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            mac_clr_q    <= 1'b1;
            dot_valid_q  <= 1'b0;
            dot_result_q <= '0;
            dot_len_q    <= '0;
            dot_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            ovf_pend_q   <= ovf_pend_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_clr_q    <= mac_clr_d;
            dot_valid_q  <= dot_valid_d;
            dot_result_q <= dot_result_d;
            dot_len_q    <= dot_len_d;
            dot_ovf_q    <= dot_ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last_i, in_a_i, in_b_i};
    end

    assign mac_a_o      = mac_a_q;
    assign mac_b_o      = mac_b_q;
    assign mac_clr_o    = mac_clr_q;
    assign dot_valid_o  = dot_valid_q;
    assign dot_result_o = dot_result_q;
    assign dot_len_o    = dot_len_q;
    assign dot_ovf_o    = dot_ovf_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: behavioural MAC, stream-level scoreboard, directed vector table
// and hand-written sequences for reset release, reset mid-vector, length limit and backpressure.
module tb_mac_operand_feeder;
    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        in_last = 1'b0;
    logic [7:0]  mac_a, mac_b;
    logic        mac_clr;
    logic [21:0] mac_result;
    logic        dot_valid;
    logic [21:0] dot_result;
    logic [6:0]  dot_len;
    logic        dot_ovf;

    always #5 clk = ~clk;

    mac_operand_feeder #(.DEPTH(DEPTH), .MAC_LAT(1), .MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
        .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_clr_o(mac_clr),
        .mac_result_i(mac_result),
        .dot_valid_o(dot_valid), .dot_result_o(dot_result),
        .dot_len_o(dot_len), .dot_ovf_o(dot_ovf)
    );

    // One-stage MAC: result updates on the edge after operands are presented.
    always @(posedge clk)
        mac_result <= mac_clr ? 22'd0 : mac_result + 22'(mac_a) * 22'(mac_b);

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
        int          gap;
        logic [21:0] exp_res;
        logic [6:0]  exp_len;
    } vec_t;

    typedef struct {
        logic [21:0] res;
        logic [6:0]  len;
        logic        ovf;
    } cap_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          push_cnt = 0;
    int          pop_cnt = 0;
    logic        saw_stall = 1'b0;
    logic [15:0] issue_q[$];
    cap_t        cap_q[$];
    cap_t        cap_log[$];
    int          issue_cyc[$];
    logic [21:0] cur_sum = 22'd0;
    int          cur_len = 0;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: vectors are cut by last (or by the length limit), sums wrap at 22 bits.
    always @(negedge clk) begin
        logic [15:0] exp_pair;
        cap_t        c;
        logic        hit;
        cyc++;
        if (rst) begin
            if (mac_a != 8'd0 || mac_b != 8'd0) begin
                issue_cyc.push_back(cyc);
                pop_cnt++;
                if (issue_q.size() == 0) begin
                    chk("unexpected issue", {mac_a, mac_b}, 32'd0);
                end else begin
                    exp_pair = issue_q.pop_front();
                    chk("issue operands", {mac_a, mac_b}, exp_pair);
                end
            end
            if (dot_valid) begin
                c = '{dot_result, dot_len, dot_ovf};
                cap_log.push_back(c);
                chk("mac_clr with dot_valid", mac_clr, 1);
                if (cap_q.size() == 0) begin
                    chk("unexpected dot_valid", dot_result, 32'hFFFF_FFFF);
                end else begin
                    c = cap_q.pop_front();
                    chk("dot_result", dot_result, c.res);
                    chk("dot_len", dot_len, c.len);
                    chk("dot_ovf", dot_ovf, c.ovf);
                end
            end
            chk("in_ready vs occupancy", in_ready, 32'((push_cnt - pop_cnt) < DEPTH));
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) begin
                push_cnt++;
                issue_q.push_back({in_a, in_b});
                cur_sum = cur_sum + 22'(in_a) * 22'(in_b);
                cur_len = (cur_len < 127) ? cur_len + 1 : 127;
`ifdef MAC_FEED_LEN_GUARD_EN
                hit = (cur_len == MAX_LEN);
`else
                hit = 1'b0;
`endif
                if (in_last || hit) begin
                    cap_q.push_back('{cur_sum, 7'(cur_len), hit && !in_last});
                    cur_sum = 22'd0;
                    cur_len = 0;
                end
            end
        end
    end

    task automatic model_reset();
        issue_q.delete();
        cap_q.delete();
        cur_sum  = 22'd0;
        cur_len  = 0;
        push_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic clear_logs();
        cap_log.delete();
        issue_cyc.delete();
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push accepted", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((cap_q.size() != 0 || issue_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain completes", 32'(n < 3000), 1);
        idle(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int k;
        tbl[0] = '{8'd134, 8'd120, 1'b0, 0, 22'd0,     7'd0};
        tbl[1] = '{8'd10,  8'd10,  1'b0, 0, 22'd0,     7'd0};
        tbl[2] = '{8'd101, 8'd21,  1'b1, 0, 22'd18301, 7'd3};
        tbl[3] = '{8'd20,  8'd20,  1'b0, 0, 22'd0,     7'd0};
        tbl[4] = '{8'd20,  8'd20,  1'b1, 0, 22'd800,   7'd2};
        tbl[5] = '{8'd134, 8'd120, 1'b0, 3, 22'd0,     7'd0};
        tbl[6] = '{8'd10,  8'd10,  1'b0, 3, 22'd0,     7'd0};
        tbl[7] = '{8'd101, 8'd21,  1'b1, 3, 22'd18301, 7'd3};
        tbl[8] = '{8'd255, 8'd255, 1'b1, 2, 22'd65025, 7'd1};
        tbl[9] = '{8'd1,   8'd1,   1'b1, 0, 22'd1,     7'd1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset mac_a", mac_a, 0);
        chk("reset mac_b", mac_b, 0);
        chk("reset mac_clr", mac_clr, 1);
        chk("reset dot_valid", dot_valid, 0);
        chk("reset dot_result", dot_result, 0);
        chk("reset dot_len", dot_len, 0);
        chk("reset dot_ovf", dot_ovf, 0);

        // Release with a single-element vector offered immediately: pushed on the first
        // edge with rst high, popped on the second, visible at the third negedge.
        @(posedge clk); #1;
        model_reset();
        clear_logs();
        rel_cyc = cyc;
        rst = 1'b1;
        push(8'd7, 8'd9, 1'b1);
        wait_done();
        if (issue_cyc.size() > 0) chk("first pop after release", issue_cyc[0] - rel_cyc, 3);
        else chk("first pop after release seen", 0, 1);
        chk("single capture count", cap_log.size(), 1);
        if (cap_log.size() > 0) begin
            chk("single dot_result", cap_log[0].res, 63);
            chk("single dot_len", cap_log[0].len, 1);
        end

        // Directed table: basic, back-to-back, gapped, single-element vectors.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].gap > 0) idle(tbl[i].gap);
            push(tbl[i].a, tbl[i].b, tbl[i].last);
        end
        wait_done();
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].last) begin
                if (k < cap_log.size()) begin
                    chk("table dot_result", cap_log[k].res, tbl[i].exp_res);
                    chk("table dot_len", cap_log[k].len, tbl[i].exp_len);
                    chk("table dot_ovf", cap_log[k].ovf, 0);
                end
                k++;
            end
        end
        chk("table capture count", cap_log.size(), k);
        if (issue_cyc.size() >= 4) begin
            chk("steady issue spacing", issue_cyc[1] - issue_cyc[0], 1);
            chk("back-to-back turnaround", issue_cyc[3] - issue_cyc[2], 3);
        end

        // 65 pairs of (255,255), last on the 65th.
        clear_logs();
        for (int i = 0; i < 65; i++) push(8'd255, 8'd255, i == 64);
        wait_done();
`ifdef MAC_FEED_LEN_GUARD_EN
        chk("guard capture count", cap_log.size(), 2);
        if (cap_log.size() >= 2) begin
            chk("guard first result", cap_log[0].res, 4161600);
            chk("guard first len", cap_log[0].len, 64);
            chk("guard first ovf", cap_log[0].ovf, 1);
            chk("guard second result", cap_log[1].res, 65025);
            chk("guard second len", cap_log[1].len, 1);
            chk("guard second ovf", cap_log[1].ovf, 0);
        end
`else
        chk("long capture count", cap_log.size(), 1);
        if (cap_log.size() >= 1) begin
            chk("long wrapped result", cap_log[0].res, 32321);
            chk("long len", cap_log[0].len, 65);
            chk("long ovf", cap_log[0].ovf, 0);
        end
`endif

        // Reset in the middle of a vector: the partial vector leaves no capture.
        clear_logs();
        push(8'd50, 8'd50, 1'b0);
        push(8'd60, 8'd60, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready forced low in reset", in_ready, 0);
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("mac_clr after reset edge", mac_clr, 1);
        chk("mac_a after reset edge", mac_a, 0);
        chk("dot_valid after reset edge", dot_valid, 0);
        @(posedge clk); #1;
        push(8'd3, 8'd4, 1'b1);
        wait_done();
        chk("reset-vector capture count", cap_log.size(), 1);
        if (cap_log.size() >= 1) begin
            chk("reset-vector dot_result", cap_log[0].res, 12);
            chk("reset-vector dot_len", cap_log[0].len, 1);
        end

        // Backpressure: 8 pairs offered continuously starting while the FSM drains.
        clear_logs();
        saw_stall = 1'b0;
        push(8'd2, 8'd3, 1'b1);
        for (int i = 0; i < 8; i++)
            push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), (i == 1) || (i == 3) || (i == 7));
        wait_done();
        chk("backpressure stall seen", saw_stall, 1);
        chk("backpressure issues", issue_cyc.size(), 9);
        chk("backpressure captures", cap_log.size(), 4);

        // Random stream with random gaps and vector lengths.
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            int g;
            g = $urandom_range(0, 2);
            if (g > 0) idle(g);
            push(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)),
                 (i == 59) || ($urandom_range(0, 3) == 0));
        end
        wait_done();
        chk("random issues", issue_cyc.size(), 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
